vpg_timing_gen: RTL and testbench
=================================

# vpg_timing_gen

Video-output timing generator directly downstream of the SDRAM read FIFO in the frame-buffer bus. It pops 32-bit pixel words from the show-ahead read FIFO and produces a registered raster stream (`vpg_de`/`vpg_hs`/`vpg_vs`/`vpg_data`) for the display encoder, one pixel per `vpg_pclk`. It also handles FIFO prefill, frame-aligned start/stop, and underflow detection.

## Interface
- `H_ACTIVE`, 320, active pixels per line
- `H_FP`, 8; `H_SYNC`, 32; `H_BP`, 40: horizontal porch/sync lengths (H_TOTAL = 400)
- `V_ACTIVE`, 240, active lines per frame
- `V_FP`, 3; `V_SYNC`, 4; `V_BP`, 6: vertical porch/sync lengths (V_TOTAL = 253)
- `PREFILL`, 256, minimum FIFO fill level (words) before the first frame starts
- `vpg_pclk` in 1: pixel clock; the only clock
- `reset` in 1: asynchronous, active-high
- `enable` in 1: run request, level-sensitive
- `Read_DATA` in 32: show-ahead FIFO head word; bits [23:0] are RGB, bits [31:24] are ignored
- `read_empty_rdfifo` in 1: FIFO empty
- `read_fifo_rdusedw` in 9: FIFO fill level
- `rd_req` out 1: FIFO pop, combinational from the registered counters
- `vpg_de` out 1: data enable
- `vpg_hs` out 1: hsync, active-low
- `vpg_vs` out 1: vsync, active-low
- `vpg_data` out 24: pixel
- `frame_start` out 1: one-cycle pulse coincident with the first `vpg_de` of a frame
- `underflow` out 1: sticky underflow flag
- `clr_underflow` in 1: synchronous clear of `underflow`

## Operation
- The state machine has two states, IDLE and RUN.
- **IDLE**
  - `h_cnt` = `v_cnt` = 0.
  - Outputs are blanked: de=0, hs=1, vs=1, data=0, rd_req=0.
  - Transition to RUN when `enable`=1 and `read_fifo_rdusedw` >= PREFILL.
- **RUN**
  - `h_cnt` counts 0..H_TOTAL-1 and wraps; `v_cnt` increments at each h wrap and counts 0..V_TOTAL-1.
  - Line order: active [0,H_ACTIVE), front porch, sync, back porch. The same order applies vertically.
  - `de_c` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - `hs_c` = 0 when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - `vs_c` = 0 when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). Vsync is line-granular.
  - `rd_req` = `de_c` && !`read_empty_rdfifo`.
  - Pixel selection: if `de_c` and the FIFO is empty, the pixel is 24'h000000 and `underflow` is set. The FIFO is never read while empty.
  - Raster position always advances; an underflow never stalls the timing.
- **Frame-boundary exit:** when `enable`=0 is sampled on the last cycle of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), return to IDLE. Deasserting `enable` mid-frame completes that frame first.
- **Underflow flag**
  - `clr_underflow` clears the flag.
  - If a clear and a new underflow occur in the same cycle, the flag stays set.
- **Reset** (asynchronous, valid at any point including mid-frame): state=IDLE, counters=0, de=0, hs=1, vs=1, data=0, frame_start=0, underflow=0.

## Timing
- Counters and state are stage 0. `rd_req` is combinational from stage 0, so the FIFO head word is consumed in the same cycle.
- All of `vpg_de`, `vpg_hs`, `vpg_vs`, `vpg_data` and `frame_start` are registered: 1-cycle latency from stage 0, mutually aligned.
- On the IDLE→RUN transition, the first stage-0 cycle has h=0, v=0. `frame_start` and the first `vpg_de` appear one cycle later.
- Line period is 400 cycles and frame period is 101 200 cycles.
- Each frame contains exactly H_ACTIVE×V_ACTIVE = 76 800 `vpg_de` cycles. It contains 76 800 `rd_req` pulses if no underflow occurs.

## Structure
- Package `vpg_pkg`:
  - default timing constants;
  - derived `H_TOTAL`/`V_TOTAL` functions;
  - `vpg_state_e` {IDLE, RUN};
  - RGB extraction helper for a 32-bit word.
- Sub-module `vpg_raster_cnt`: h/v counters with wrap, a `frame_last` flag, and a synchronous hold-to-zero input.
- Top level: FSM, FIFO pop logic, output register stage, underflow flag.

## Test plan
- **Prefill gating:** `enable`=1 with `rdusedw`=255 → stays IDLE with outputs blank. Raise `rdusedw` to 256 → `frame_start` occurs 2 cycles later and the first `vpg_data` equals `Read_DATA[23:0]`.
- **Full frame with an always-nonempty FIFO model fed words 1,2,3,…** → 76 800 de cycles. `vpg_data` sequence is 1..76800 in order. hs low for 32 cycles starting at h=328. vs low on lines 243–246. Next `frame_start` comes 101 200 cycles after the first.
- **Underflow:** force empty for 5 active cycles mid-line → `vpg_data`=0 and no `rd_req` on those cycles. `underflow`=1 until `clr_underflow`. Raster timing is unchanged.
- **Simultaneous clear and underflow in one cycle** → `underflow` remains 1.
- **Deassert `enable` at line 100** → frame completes, returns to IDLE at frame end, no further de.
- **Assert `reset` mid-line** → all outputs take reset values immediately and the block resumes from IDLE after release.

Source files
------------

// File: rtl/vpg_pkg.sv
// Shared timing defaults, state encoding and pixel helpers for the video timing generator.
// No logic of its own; totals are derived so a single porch change cannot desynchronise them.
package vpg_pkg;

    localparam int H_ACTIVE_D = 320;
    localparam int H_FP_D     = 8;
    localparam int H_SYNC_D   = 32;
    localparam int H_BP_D     = 40;
    localparam int V_ACTIVE_D = 240;
    localparam int V_FP_D     = 3;
    localparam int V_SYNC_D   = 4;
    localparam int V_BP_D     = 6;
    localparam int PREFILL_D  = 256;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vpg_state_e;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // The top byte of a FIFO word carries no colour information.
    function automatic logic [23:0] rgb_of(input logic [31:0] word);
        return word[23:0];
    endfunction

endpackage

// File: rtl/vpg_raster_cnt.sv
// Horizontal/vertical raster position counters; updates every cycle, zero-held while i_hold.
// Zero latency on o_frame_last (decoded from the registered counters); no backpressure.
module vpg_raster_cnt #(
    parameter int H_TOTAL = 400,
    parameter int V_TOTAL = 253,
    parameter int HW      = $clog2(H_TOTAL),
    parameter int VW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_hold,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_frame_last
);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last     = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last     = (r_v_cnt == VW'(V_TOTAL - 1));
    assign o_frame_last = w_h_last && w_v_last;
    assign o_h_cnt      = r_h_cnt;
    assign o_v_cnt      = r_v_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_hold) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vpg_timing_gen.sv
// Raster timing generator popping a show-ahead FIFO; rd_req is same-cycle, video outputs 1 cycle later.
// Never stalls: an empty FIFO during active video yields black pixels and sets the sticky underflow flag.
module vpg_timing_gen
    import vpg_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int PREFILL  = PREFILL_D
) (
    input  logic        vpg_pclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] Read_DATA,
    input  logic        read_empty_rdfifo,
    input  logic [8:0]  read_fifo_rdusedw,
    output logic        rd_req,
    output logic        vpg_de,
    output logic        vpg_hs,
    output logic        vpg_vs,
    output logic [23:0] vpg_data,
    output logic        frame_start,
    output logic        underflow,
    input  logic        clr_underflow
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    vpg_state_e    r_state;
    vpg_state_e    w_state_nxt;
    logic          w_run;
    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_frame_last;
    logic          w_de_c;
    logic          w_hs_c;
    logic          w_vs_c;
    logic          w_rd;
    logic          w_uf_evt;
    logic          w_fs_c;
    logic [23:0]   w_pix;

    logic          r_de;
    logic          r_hs;
    logic          r_vs;
    logic [23:0]   r_data;
    logic          r_fs;
    logic          r_underflow;

    vpg_raster_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .HW      (HW),
        .VW      (VW)
    ) u_cnt (
        .i_clk        (vpg_pclk),
        .i_rst        (reset),
        .i_hold       (!w_run),
        .o_h_cnt      (w_h_cnt),
        .o_v_cnt      (w_v_cnt),
        .o_frame_last (w_frame_last)
    );

    always_ff @(posedge vpg_pclk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Stopping is only allowed on the last pixel so the display never sees a truncated frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable && (read_fifo_rdusedw >= 9'(PREFILL))) w_state_nxt = RUN;
            RUN:     if (w_frame_last && !enable) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_run    = (r_state == RUN);
        w_de_c   = w_run && (w_h_cnt < HW'(H_ACTIVE)) && (w_v_cnt < VW'(V_ACTIVE));
        w_hs_c   = !(w_run && (w_h_cnt >= HW'(H_ACTIVE + H_FP))
                           && (w_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
        w_vs_c   = !(w_run && (w_v_cnt >= VW'(V_ACTIVE + V_FP))
                           && (w_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
        w_rd     = w_de_c && !read_empty_rdfifo;
        w_uf_evt = w_de_c && read_empty_rdfifo;
        w_fs_c   = w_de_c && (w_h_cnt == '0) && (w_v_cnt == '0);
        w_pix    = w_rd ? rgb_of(Read_DATA) : 24'h000000;
    end

    assign rd_req = w_rd;

    always_ff @(posedge vpg_pclk or posedge reset) begin
        if (reset) begin
            r_de   <= 1'b0;
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
            r_data <= '0;
            r_fs   <= 1'b0;
        end else begin
            r_de   <= w_de_c;
            r_hs   <= w_hs_c;
            r_vs   <= w_vs_c;
            r_data <= w_pix;
            r_fs   <= w_fs_c;
        end
    end

    // A fresh underflow outranks a clear so a same-cycle event is never lost.
    always_ff @(posedge vpg_pclk or posedge reset) begin
        if (reset)              r_underflow <= 1'b0;
        else if (w_uf_evt)      r_underflow <= 1'b1;
        else if (clr_underflow) r_underflow <= 1'b0;
    end

    assign vpg_de      = r_de;
    assign vpg_hs      = r_hs;
    assign vpg_vs      = r_vs;
    assign vpg_data    = r_data;
    assign frame_start = r_fs;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_vpg_timing_gen.sv
// Randomised scoreboard bench for vpg_timing_gen using a reduced raster so whole frames fit the run.
module tb_vpg_timing_gen;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int PF = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] rdata;
    logic        empty;
    logic [8:0]  used;
    logic        clr;
    logic        rd_req, vpg_de, vpg_hs, vpg_vs, frame_start, underflow;
    logic [23:0] vpg_data;

    always #5 clk = ~clk;

    vpg_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .PREFILL  (PF)
    ) dut (
        .vpg_pclk          (clk),
        .reset             (rst),
        .enable            (en),
        .Read_DATA         (rdata),
        .read_empty_rdfifo (empty),
        .read_fifo_rdusedw (used),
        .rd_req            (rd_req),
        .vpg_de            (vpg_de),
        .vpg_hs            (vpg_hs),
        .vpg_vs            (vpg_vs),
        .vpg_data          (vpg_data),
        .frame_start       (frame_start),
        .underflow         (underflow),
        .clr_underflow     (clr)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] data;
        logic        fs;
        logic        uf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a linear position within the frame, split into line/pixel by division.
    bit   m_run = 1'b0;
    int   m_pos = 0;
    bit   m_uf  = 1'b0;
    int   word  = 1;

    bit   stats_on = 1'b0;
    int   frames_measured = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit emp, input bit c, input logic [8:0] u);
        exp_t x;
        bit   de, rd, ue;
        int   px, ln;
        @(negedge clk);
        rst   = r;
        en    = e;
        empty = emp;
        clr   = c;
        used  = u;
        rdata = {8'($urandom), 24'(word)};
        #2;
        x  = '0;
        rd = 1'b0;
        if (r) begin
            m_run = 1'b0; m_pos = 0; m_uf = 1'b0;
            x.hs = 1'b1; x.vs = 1'b1;
            chk("rst_now_de", {31'd0, vpg_de}, 32'd0);
            chk("rst_now_hs_vs", {30'd0, vpg_hs, vpg_vs}, 32'd3);
            chk("rst_now_data", {8'd0, vpg_data}, 32'd0);
            chk("rst_now_fs_uf", {30'd0, frame_start, underflow}, 32'd0);
        end else begin
            de = 1'b0; ue = 1'b0;
            x.hs = 1'b1; x.vs = 1'b1;
            if (m_run) begin
                px   = m_pos % HT;
                ln   = m_pos / HT;
                de   = (px < HA) && (ln < VA);
                x.hs = !((px >= HA + HFP) && (px < HA + HFP + HS));
                x.vs = !((ln >= VA + VFP) && (ln < VA + VFP + VS));
                rd   = de && !emp;
                ue   = de && emp;
                x.de = de;
                x.data = rd ? rdata[23:0] : 24'd0;
                x.fs = (m_pos == 0);
                if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    if (!e) m_run = 1'b0;
                end else begin
                    m_pos++;
                end
            end else if (e && (u >= PF)) begin
                m_run = 1'b1;
                m_pos = 0;
            end
            if (ue)     m_uf = 1'b1;
            else if (c) m_uf = 1'b0;
        end
        x.uf = m_uf;
        chk("rd_req", {31'd0, rd_req}, {31'd0, rd});
        if (rd) word++;
        q.push_back(x);
    endtask

    task automatic wait_pos(input int target, input string name);
        int n;
        n = 0;
        while (!(m_run && m_pos == target) && n < 2 * FRAME) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 9'd300);
            n++;
        end
        if (n >= 2 * FRAME) begin
            checks++;
            errors++;
            $display("FAIL %s: position %0d not reached, got %0d", name, target, m_pos);
        end
    endtask

    // Monitor: one expected output word per clock, compared just after the edge.
    initial begin
        exp_t x;
        int   mcyc, fs_cyc, de_cnt;
        bit   fs_seen;
        mcyc = 0; fs_cyc = 0; de_cnt = 0; fs_seen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("vpg_de", {31'd0, vpg_de}, {31'd0, x.de});
                chk("vpg_hs", {31'd0, vpg_hs}, {31'd0, x.hs});
                chk("vpg_vs", {31'd0, vpg_vs}, {31'd0, x.vs});
                chk("vpg_data", {8'd0, vpg_data}, {8'd0, x.data});
                chk("frame_start", {31'd0, frame_start}, {31'd0, x.fs});
                chk("underflow", {31'd0, underflow}, {31'd0, x.uf});
            end
            if (stats_on) begin
                if (frame_start) begin
                    if (fs_seen) begin
                        chk("frame_de_count", de_cnt, HA * VA);
                        chk("frame_period", mcyc - fs_cyc, FRAME);
                        frames_measured++;
                    end
                    fs_seen = 1'b1;
                    fs_cyc  = mcyc;
                    de_cnt  = 0;
                end
                if (vpg_de) de_cnt++;
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; empty = 1'b0; clr = 1'b0; used = '0; rdata = '0;
        #1;
        chk("reset_de", {31'd0, vpg_de}, 32'd0);
        chk("reset_hs_vs", {30'd0, vpg_hs, vpg_vs}, 32'd3);
        chk("reset_data", {8'd0, vpg_data}, 32'd0);
        chk("reset_fs_uf", {30'd0, frame_start, underflow}, 32'd0);
        chk("reset_rd_req", {31'd0, rd_req}, 32'd0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 9'd0);

        // Prefill gate: one word short keeps the block idle.
        repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 9'd255);
        stats_on = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 9'd256);
        repeat (2 * FRAME + 20) step(1'b0, 1'b1, 1'b0, 1'b0, 9'($urandom));
        stats_on = 1'b0;
        chk("frames_measured", {31'd0, frames_measured >= 1}, 32'd1);

        // Five consecutive empty cycles in the middle of an active line.
        wait_pos(2 * HT + 5, "wait_underflow");
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 9'd300);
        repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0, 9'd300);
        step(1'b0, 1'b1, 1'b0, 1'b1, 9'd300);

        // Clear coincident with a new underflow must leave the flag set.
        wait_pos(4 * HT + 3, "wait_clr_collision");
        step(1'b0, 1'b1, 1'b1, 1'b1, 9'd300);
        step(1'b0, 1'b1, 1'b0, 1'b0, 9'd300);
        step(1'b0, 1'b1, 1'b0, 1'b1, 9'd300);

        repeat (700) step(1'b0, 1'b1, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 15) == 0, 9'($urandom));

        // Drop enable on line 3: the frame finishes, then the block stays idle.
        wait_pos(3 * HT, "wait_disable");
        repeat (FRAME + 50) step(1'b0, 1'b0, $urandom_range(0, 7) == 0, 1'b0, 9'($urandom));

        // Restart, then reset in the middle of line 1.
        step(1'b0, 1'b1, 1'b0, 1'b0, 9'd400);
        wait_pos(HT + 7, "wait_reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, 9'd400);
        step(1'b1, 1'b1, 1'b0, 1'b0, 9'd400);
        repeat (300) step(1'b0, 1'b1, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 31) == 0, 9'($urandom));

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
